// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor. It computes diff = a - b one bit
//   per clock, LSB first, through a single registered full-subtractor cell.
//   A borrow flop takes the place of the carry chain. The result lands after
//   WIDTH clocks and is announced by a one-cycle done pulse.
//
// Ports
//   clk    : system clock, rising-edge active
//   rst_n  : synchronous active-low reset
//   start  : request; sampled only while idle
//   a, b   : minuend / subtrahend, captured on the accepting edge
//   busy   : high while an operation is in progress (exactly WIDTH cycles)
//   done   : single-cycle pulse; diff/borrow/ovf valid from this cycle on
//   diff   : (a - b) mod 2^WIDTH, held until the next completion
//   borrow : unsigned borrow out (a < b unsigned)
//   ovf    : signed overflow of a - b
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
  logic [CW-1:0]    cnt;
  logic             br, br_next, d;
  logic             a_msb, b_msb;
  logic             accept, last_bit;

  // Full-subtractor cell on the current LSBs, plus the control decode.
  // accept marks the edge that captures operands; last_bit marks the edge
  // that processes bit WIDTH-1 and therefore completes the operation.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    d          = a_sh[0] ^ b_sh[0] ^ br;
    br_next    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    r_next     = {d, r_sh[WIDTH-1:1]};
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_bit   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath and registered outputs. The result registers are written only
  // at completion so they never show partial results during a run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        r_sh  <= '0;
        cnt   <= '0;
        br    <= 1'b0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
        busy  <= 1'b1;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= r_next;
        br   <= br_next;
        cnt  <= cnt + 1'b1;
        if (last_bit) begin
          // d is the result MSB being shifted in on this final edge
          diff   <= r_next;
          borrow <= br_next;
          ovf    <= (a_msb != b_msb) && (d != a_msb);
          done   <= 1'b1;
          busy   <= 1'b0;
          cnt    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Bench for serial_subtractor. An 8-bit instance runs directed vectors
//   (including ignored mid-run start, back-to-back start on the done cycle
//   and a mid-run reset); a 4-bit instance is swept over all operand pairs.
//   An arithmetic model predicts busy/done/diff/borrow/ovf for both
//   instances and is compared against them on every cycle.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, borrow8, ovf8;
  logic [7:0] diff8;
  logic       busy4, done4, borrow4, ovf4;
  logic [3:0] diff4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .ovf(ovf4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: returns {ovf, borrow, diff}
  function automatic logic [33:0] ref_sub(input int w, input int av, input int bv);
    int d, sa, sb, sd;
    logic bo, ov;
    d  = (av - bv) & ((1 << w) - 1);
    bo = (av < bv);
    sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    sd = sa - sb;
    ov = (sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1)));
    return {ov, bo, 32'(d)};
  endfunction

  // Cycle model: an accepted op completes WIDTH edges later; nothing else
  // is accepted while an op is pending; reset discards everything.
  logic        started = 1'b0;
  int          m8_left, m4_left;
  logic        m8_busy, m8_done, m8_bo, m8_ov, p8_bo, p8_ov;
  logic        m4_busy, m4_done, m4_bo, m4_ov, p4_bo, p4_ov;
  logic [31:0] m8_diff, m4_diff, p8_diff, p4_diff;

  always @(posedge clk) begin
    if (!rst_n) begin
      started <= 1'b1;
      m8_left <= 0; m8_busy <= 1'b0; m8_done <= 1'b0;
      m8_diff <= '0; m8_bo <= 1'b0; m8_ov <= 1'b0;
    end else begin
      m8_done <= 1'b0;
      if (m8_left > 0) begin
        m8_left <= m8_left - 1;
        if (m8_left == 1) begin
          m8_busy <= 1'b0; m8_done <= 1'b1;
          m8_diff <= p8_diff; m8_bo <= p8_bo; m8_ov <= p8_ov;
        end
      end else if (start8) begin
        m8_left <= 8;
        m8_busy <= 1'b1;
        {p8_ov, p8_bo, p8_diff} <= ref_sub(8, int'(a8), int'(b8));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m4_left <= 0; m4_busy <= 1'b0; m4_done <= 1'b0;
      m4_diff <= '0; m4_bo <= 1'b0; m4_ov <= 1'b0;
    end else begin
      m4_done <= 1'b0;
      if (m4_left > 0) begin
        m4_left <= m4_left - 1;
        if (m4_left == 1) begin
          m4_busy <= 1'b0; m4_done <= 1'b1;
          m4_diff <= p4_diff; m4_bo <= p4_bo; m4_ov <= p4_ov;
        end
      end else if (start4) begin
        m4_left <= 4;
        m4_busy <= 1'b1;
        {p4_ov, p4_bo, p4_diff} <= ref_sub(4, int'(a4), int'(b4));
      end
    end
  end

  // Every cycle: all outputs of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      checkOutput("busy8",   busy8,   m8_busy);
      checkOutput("done8",   done8,   m8_done);
      checkOutput("diff8",   diff8,   m8_diff);
      checkOutput("borrow8", borrow8, m8_bo);
      checkOutput("ovf8",    ovf8,    m8_ov);
      checkOutput("busy4",   busy4,   m4_busy);
      checkOutput("done4",   done4,   m4_done);
      checkOutput("diff4",   diff4,   m4_diff);
      checkOutput("borrow4", borrow4, m4_bo);
      checkOutput("ovf4",    ovf4,    m4_ov);
    end
  end

  // Presents one request; returns at the negedge after the accepting edge
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic applyStimulus4(input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic waitDone8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic waitDone4(output int cyc);
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One 8-bit op with operands scrambled mid-run and literal expectations
  task automatic runOp8(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int cyc;
    applyStimulus(av, bv);
    a8 = ~av;
    b8 = bv ^ 8'h5A;
    waitDone8(cyc);
    checkOutput({name, "_latency"}, cyc, 8);
    checkOutput({name, "_diff"},    diff8, ed);
    checkOutput({name, "_borrow"},  borrow8, eb);
    checkOutput({name, "_ovf"},     ovf8, eo);
  endtask

  initial begin
    int cyc;
    int n_done;
    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy8, 1'b0);
    checkOutput("reset_done", done8, 1'b0);
    checkOutput("reset_diff", diff8, 8'h00);
    rst_n = 1'b1;

    runOp8("t1",     8'h37, 8'h12, 8'h25, 1'b0, 1'b0);
    runOp8("t2a",    8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    runOp8("t2b",    8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    runOp8("t3a",    8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    runOp8("t3b",    8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);

    // start pulsed in cycle 3 of RUN must be ignored
    applyStimulus(8'h37, 8'h12);
    repeat (2) @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitDone8(cyc);
    checkOutput("t4_latency", cyc, 5);
    checkOutput("t4_diff",    diff8, 8'h25);
    checkOutput("t4_borrow",  borrow8, 1'b0);
    // start on the done cycle is accepted
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitDone8(cyc);
    checkOutput("t4b_latency", cyc, 8);
    checkOutput("t4b_diff",    diff8, 8'hF0);
    checkOutput("t4b_borrow",  borrow8, 1'b1);
    checkOutput("t4b_ovf",     ovf8, 1'b0);

    // reset in cycle 4 of RUN aborts the op
    applyStimulus(8'h37, 8'h12);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t5_busy", busy8, 1'b0);
    checkOutput("t5_done", done8, 1'b0);
    checkOutput("t5_diff", diff8, 8'h00);
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    checkOutput("t5_no_done", n_done, 0);

    // 4-bit exhaustive sweep; values checked by the per-cycle compare
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        applyStimulus4(4'(ai), 4'(bi));
        a4 = 4'(~ai);
        waitDone4(cyc);
        checkOutput("t6_latency", cyc, 4);
        if (ai == 8 && bi == 1) begin
          checkOutput("t6_8m1_diff", diff4, 4'h7);
          checkOutput("t6_8m1_ovf",  ovf4, 1'b1);
        end
        if (ai == 3 && bi == 9) begin
          checkOutput("t6_3m9_diff",   diff4, 4'hA);
          checkOutput("t6_3m9_borrow", borrow4, 1'b1);
          checkOutput("t6_3m9_ovf",    ovf4, 1'b1);
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no completion, expected end of test");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock, LSB first.
- Uses a single registered full-subtractor cell (borrow chain in place of carry chain), so area stays minimal.
- Companion to the combinational full-adder cell in the combination-logic library.
- Sits in datapaths that trade latency for area; start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk     input   1      system clock, rising-edge active
rst_n   input   1      synchronous active-low reset
start   input   1      request; sampled only in IDLE
a       input   WIDTH  minuend; sampled on the accepting edge
b       input   WIDTH  subtrahend; sampled on the accepting edge
busy    output  1      high while an operation is in progress
done    output  1      single-cycle pulse; result outputs valid from this cycle
diff    output  WIDTH  result a - b modulo 2^WIDTH
borrow  output  1      unsigned borrow out (1 when a < b unsigned)
ovf     output  1      signed overflow of a - b

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous, active-low, named rst_n; clock is clk.
  - While rst_n = 0 at a rising edge: state <= IDLE; busy, done, diff, borrow, ovf <= 0; internal shift registers, bit counter and borrow flop <= 0.
- States:
  - IDLE:
    - busy = 0.
    - If start = 1 at an edge: latch a and b into shift registers A_sh and B_sh, clear the borrow flop, clear the bit counter, go to RUN.
    - If start = 0: stay in IDLE.
  - RUN:
    - busy = 1.
    - Each edge processes bit i = counter, taking ai = A_sh[0] and bi = B_sh[0]:
      - d = ai ^ bi ^ br
      - br_next = (~ai & bi) | (~(ai ^ bi) & br)
    - d shifts into the MSB of result shift register R_sh; A_sh and B_sh shift right; counter increments.
  - Completion (the edge processing bit WIDTH-1):
    - diff <= completed R_sh; borrow <= br_next.
    - ovf <= (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operand MSBs.
    - done <= 1; busy <= 0; state <= IDLE.
- Latency:
  - Start accepted at edge T0; done is high during the cycle following edge T0+WIDTH.
  - busy is high for exactly WIDTH cycles.
- Output stability:
  - diff, borrow and ovf update only at completion.
  - They hold their value through the next operation until its completion, so they never glitch mid-run.
- done is high for exactly one cycle and then returns to 0.
- Boundary conditions:
  - start while busy = 1: ignored; operands are not resampled and there is no queuing.
  - start during the done cycle: accepted, since the state is IDLE; back-to-back operations give one result every WIDTH+1 cycles.
  - a and b changing during RUN: no effect on the result.
  - Reset mid-operation: operation aborted, no done pulse, all outputs 0 on the next cycle.
  - a == b: diff = 0, borrow = 0, ovf = 0.
  - The counter must not wrap into a second pass; exactly WIDTH bits are processed.
- Purely synchronous: no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=8, a=0x37, b=0x12, start for 1 cycle -> busy high 8 cycles, then done pulse with diff=0x25, borrow=0, ovf=0.
2. a=0x00, b=0x01 -> diff=0xFF, borrow=1, ovf=0; a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
3. a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1; a=0x5A, b=0x5A -> diff=0x00, borrow=0, ovf=0.
4. Pulse start again at cycle 3 of RUN with a=0x01, b=0x01 -> ignored; first result (0x37-0x12=0x25) delivered; start asserted on the done cycle with a=0x10, b=0x20 -> accepted, next done gives diff=0xF0, borrow=1.
5. Drop rst_n for 1 cycle at cycle 4 of RUN -> busy=0, done=0, diff=0 next cycle; no done pulse ever appears for that operation.
6. WIDTH=4, exhaustive sweep of all 256 (a, b) pairs -> diff, borrow and ovf match the reference model (a - b) mod 16, a < b, and the signed overflow rule; done latency always 4 cycles.
